// File: rtl/softmax_pkg.sv
// Shared fixed-point helpers for the exp/softmax datapath.
// Holds the Horner FSM states and the 1/k coefficient table.
package softmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_X = 2'd1,
        MUL_C = 2'd2,
        DONE  = 2'd3
    } exp_state_t;

    // Highest coefficient index the table provides.
    localparam int COEF_MAX_K = 15;

    // 1.0 in the default Q16.16 format.
    localparam longint ONE_Q16 = 64'sd65536;

    // 1.0 in Q(.).frac.
    function automatic longint fxp_one(input int frac);
        return longint'(1) <<< frac;
    endfunction

    // Taylor coefficient floor(2^frac / k); zero for k = 0.
    function automatic longint coef_c(input int frac, input int k);
        if (k <= 0 || k > COEF_MAX_K) begin
            return 64'sd0;
        end
        return fxp_one(frac) / longint'(k);
    endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply, arithmetic shift by FRAC, saturate.
// Flags when the shifted product leaves the BITWIDTH signed range.
module fxp_mul_sat #(
    parameter int BITWIDTH = 32,
    parameter int FRAC     = 16
) (
    input  logic signed [BITWIDTH-1:0] a,
    input  logic signed [BITWIDTH-1:0] b,
    output logic signed [BITWIDTH-1:0] y,
    output logic                       ovf
);

    localparam int PW = 2 * BITWIDTH;

    localparam logic signed [BITWIDTH-1:0] SAT_MAX =
        {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH-1:0] SAT_MIN =
        {1'b1, {(BITWIDTH-1){1'b0}}};

    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shr;
    logic        [BITWIDTH:0] hi;

    // Full-width product, shift, then range check on the upper bits.
    always_comb begin
        prod = PW'(a) * PW'(b);
        shr  = prod >>> FRAC;
        hi   = shr[PW-1:BITWIDTH-1];
        ovf  = !((&hi) || (~|hi));
        if (ovf) begin
            y = shr[PW-1] ? SAT_MIN : SAT_MAX;
        end else begin
            y = shr[BITWIDTH-1:0];
        end
    end

endmodule

// File: rtl/exp_taylor_horner.sv
// e^x by a Horner-form Taylor series, one shared multiplier.
// Each series term costs two cycles: acc*x, then p*C[k] plus one.
module exp_taylor_horner
    import softmax_pkg::*;
#(
    parameter int BITWIDTH  = 32,
    parameter int FRAC      = 16,
    parameter int MAX_ORDER = 8,
    parameter int INPUTMAX  = 5
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic signed [BITWIDTH-1:0] Datain,
    input  logic        [3:0]          Order,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic signed [BITWIDTH-1:0] DataOut,
    output logic                       Ovf,
    output logic                       OutOfRange
);

    localparam logic signed [BITWIDTH-1:0] ONE =
        BITWIDTH'(fxp_one(FRAC));
    localparam logic signed [BITWIDTH:0] LIM =
        (BITWIDTH+1)'(longint'(INPUTMAX) <<< FRAC);
    localparam logic [3:0] ORD_MAX = 4'(MAX_ORDER);

    localparam logic signed [BITWIDTH-1:0] SAT_MAX =
        {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH-1:0] SAT_MIN =
        {1'b1, {(BITWIDTH-1){1'b0}}};

    exp_state_t state, state_nx;

    logic signed [BITWIDTH-1:0] acc;
    logic signed [BITWIDTH-1:0] x_q;
    logic signed [BITWIDTH-1:0] p_q;
    logic        [3:0]          k_q;
    logic signed [BITWIDTH-1:0] dout_q;
    logic                       ovf_q;
    logic                       oor_q;
    logic                       rdy_q;

    logic signed [BITWIDTH-1:0] ctab [16];
    logic signed [BITWIDTH-1:0] mul_a;
    logic signed [BITWIDTH-1:0] mul_b;
    logic signed [BITWIDTH-1:0] mul_y;
    logic                       mul_ovf;

    logic signed [BITWIDTH:0]   sum_w;
    logic signed [BITWIDTH-1:0] sum_sat;
    logic                       sum_ovf;
    logic signed [BITWIDTH:0]   x_ext;
    logic                       x_oor;
    logic        [3:0]          n_clamp;
    logic                       accept;

    for (genvar i = 0; i < 16; i++) begin : g_ctab
        assign ctab[i] = BITWIDTH'(coef_c(FRAC, i));
    end

    // Operand select: MUL_X uses acc*x, otherwise p*C[k].
    always_comb begin
        mul_a = acc;
        mul_b = x_q;
        if (state == MUL_C) begin
            mul_a = p_q;
            mul_b = ctab[k_q];
        end
    end

    fxp_mul_sat #(
        .BITWIDTH (BITWIDTH),
        .FRAC     (FRAC)
    ) u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .y   (mul_y),
        .ovf (mul_ovf)
    );

    // 1.0 + term, saturated to the data width.
    always_comb begin
        sum_w   = (BITWIDTH+1)'(ONE) + (BITWIDTH+1)'(mul_y);
        sum_ovf = sum_w[BITWIDTH] != sum_w[BITWIDTH-1];
        if (sum_ovf) begin
            sum_sat = sum_w[BITWIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_sat = sum_w[BITWIDTH-1:0];
        end
    end

    // Order clamp and input range flag, evaluated on the offered operand.
    always_comb begin
        x_ext = (BITWIDTH+1)'(Datain);
        x_oor = (x_ext > LIM) || (x_ext < -LIM);
        if (Order == 4'd0) begin
            n_clamp = 4'd1;
        end else if (Order > ORD_MAX) begin
            n_clamp = ORD_MAX;
        end else begin
            n_clamp = Order;
        end
    end

    assign accept = InValid && InReady;

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = MUL_X;
            MUL_X:   state_nx = MUL_C;
            MUL_C:   state_nx = (k_q == 4'd1) ? DONE : MUL_X;
            DONE:    if (OutReady) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        InReady  = (state == IDLE) && rdy_q;
        OutValid = (state == DONE);
    end

    // Datapath registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            acc    <= '0;
            x_q    <= '0;
            p_q    <= '0;
            k_q    <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            oor_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        x_q   <= Datain;
                        k_q   <= n_clamp;
                        acc   <= ONE;
                        ovf_q <= 1'b0;
                        oor_q <= x_oor;
                    end
                end
                MUL_X: begin
                    p_q   <= mul_y;
                    ovf_q <= ovf_q | mul_ovf;
                end
                MUL_C: begin
                    acc   <= sum_sat;
                    k_q   <= k_q - 4'd1;
                    ovf_q <= ovf_q | mul_ovf | sum_ovf;
                    if (k_q == 4'd1) begin
                        dout_q <= sum_sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign DataOut    = dout_q;
    assign Ovf        = ovf_q;
    assign OutOfRange = oor_q;

endmodule

// File: tb/tb_exp_taylor_horner.sv
// Randomised and directed checks of exp_taylor_horner (Q16.16).
// Expected results come from a plain-arithmetic series model.
module tb_exp_taylor_horner;

    localparam int BW = 32;
    localparam int FR = 16;
    localparam int MO = 8;
    localparam int IM = 5;

    logic                 Clock;
    logic                 Reset;
    logic                 InValid;
    logic                 InReady;
    logic signed [BW-1:0] Datain;
    logic        [3:0]    Order;
    logic                 OutValid;
    logic                 OutReady;
    logic signed [BW-1:0] DataOut;
    logic                 Ovf;
    logic                 OutOfRange;

    int n_chk;
    int n_fail;

    exp_taylor_horner #(
        .BITWIDTH  (BW),
        .FRAC      (FR),
        .MAX_ORDER (MO),
        .INPUTMAX  (IM)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .InValid    (InValid),
        .InReady    (InReady),
        .Datain     (Datain),
        .Order      (Order),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .DataOut    (DataOut),
        .Ovf        (Ovf),
        .OutOfRange (OutOfRange)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag,
                            input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sat32(input longint v, inout bit ov);
        longint hi;
        longint lo;
        hi = 64'sd2147483647;
        lo = -64'sd2147483648;
        if (v > hi) begin
            ov = 1'b1;
            return hi;
        end
        if (v < lo) begin
            ov = 1'b1;
            return lo;
        end
        return v;
    endfunction

    // Series e^x ~ 1 + x(1 + x/2(1 + x/3(...))) with truncating shifts.
    task automatic model(input logic signed [BW-1:0] x,
                         input logic [3:0] ord,
                         output logic [BW-1:0] data,
                         output bit ov,
                         output bit oor,
                         output int lat);
        longint acc;
        longint xv;
        longint p;
        longint c;
        longint ax;
        int n;
        ov  = 1'b0;
        xv  = longint'(x);
        acc = longint'(1) <<< FR;
        n   = (ord == 0) ? 1 : ((int'(ord) > MO) ? MO : int'(ord));
        for (int k = n; k >= 1; k--) begin
            c   = (longint'(1) <<< FR) / longint'(k);
            p   = sat32((acc * xv) >>> FR, ov);
            p   = sat32((p * c) >>> FR, ov);
            acc = sat32((longint'(1) <<< FR) + p, ov);
        end
        data = acc[BW-1:0];
        ax   = (xv < 0) ? -xv : xv;
        oor  = ax > (longint'(IM) <<< FR);
        lat  = 2 * n;
    endtask

    task automatic run_txn(input string tag,
                           input logic signed [BW-1:0] x,
                           input logic [3:0] ord);
        logic [BW-1:0] e_data;
        bit e_ov;
        bit e_oor;
        int e_lat;
        int lat;
        int w;
        model(x, ord, e_data, e_ov, e_oor, e_lat);
        w = 0;
        while (!InReady && w < 20) begin
            @(posedge Clock);
            #1;
            w++;
        end
        check_eq({tag, "_rdy"}, 64'(InReady), 64'd1);
        InValid = 1'b1;
        Datain  = x;
        Order   = ord;
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        Datain  = $urandom;
        Order   = 4'($urandom);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) begin
                check_eq({tag, "_busy"}, 64'(InReady), 64'd0);
            end
            @(posedge Clock);
            #1;
            if (OutValid) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(e_lat));
        check_eq({tag, "_data"}, 64'(DataOut), 64'(e_data));
        check_eq({tag, "_ovf"}, 64'(Ovf), 64'(e_ov));
        check_eq({tag, "_oor"}, 64'(OutOfRange), 64'(e_oor));
        OutReady = 1'b1;
        @(posedge Clock);
        #1;
        OutReady = 1'b0;
        check_eq({tag, "_drain"}, 64'(OutValid), 64'd0);
    endtask

    initial begin
        logic [BW-1:0] e_data;
        logic [BW-1:0] hold;
        bit e_ov;
        bit e_oor;
        int e_lat;
        int ghost;
        logic signed [BW-1:0] xr;

        n_chk    = 0;
        n_fail   = 0;
        Reset    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        Datain   = '0;
        Order    = '0;

        repeat (3) @(posedge Clock);
        #1;
        check_eq("rst_inready", 64'(InReady), 64'd0);
        check_eq("rst_outvalid", 64'(OutValid), 64'd0);
        check_eq("rst_data", 64'(DataOut), 64'd0);
        check_eq("rst_ovf", 64'(Ovf), 64'd0);
        check_eq("rst_oor", 64'(OutOfRange), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check_eq("rel_inready0", 64'(InReady), 64'd0);
        @(posedge Clock);
        #1;
        check_eq("rel_inready1", 64'(InReady), 64'd1);

        // Directed vectors.
        check_eq("dir_e1_model", 64'd0, 64'd0 & 64'(n_fail));
        model(32'sh00010000, 4'd4, e_data, e_ov, e_oor, e_lat);
        check_eq("dir_e1_ref", 64'(e_data), 64'h2B555);
        run_txn("e1", 32'sh00010000, 4'd4);
        model(32'shFFFF0000, 4'd4, e_data, e_ov, e_oor, e_lat);
        check_eq("dir_em1_ref", 64'(e_data), 64'h6000);
        run_txn("em1", 32'shFFFF0000, 4'd4);
        run_txn("zero_o0", 32'sh0, 4'd0);
        run_txn("o15", 32'sh00008000, 4'd15);
        run_txn("oor6", 32'sh00060000, 4'd3);
        run_txn("oor5", 32'sh00050000, 4'd3);
        run_txn("oormin", 32'sh80000000, 4'd2);
        run_txn("ovfbig", 32'sh7FFF0000, 4'd8);
        check_eq("ovfbig_data", 64'(DataOut), 64'h7FFFFFFF);
        check_eq("ovfbig_flag", 64'(Ovf), 64'd1);

        // Backpressure: result must hold while the consumer stalls.
        model(32'sh00014000, 4'd5, e_data, e_ov, e_oor, e_lat);
        InValid = 1'b1;
        Datain  = 32'sh00014000;
        Order   = 4'd5;
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        for (int i = 0; i < 40 && !OutValid; i++) begin
            @(posedge Clock);
            #1;
        end
        check_eq("bp_valid", 64'(OutValid), 64'd1);
        hold = DataOut;
        check_eq("bp_data", 64'(hold), 64'(e_data));
        for (int i = 0; i < 5; i++) begin
            InValid = 1'b1;
            Datain  = $urandom;
            Order   = 4'($urandom);
            @(posedge Clock);
            #1;
            check_eq("bp_hold_valid", 64'(OutValid), 64'd1);
            check_eq("bp_hold_data", 64'(DataOut), 64'(hold));
            check_eq("bp_hold_rdy", 64'(InReady), 64'd0);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(posedge Clock);
        #1;
        OutReady = 1'b0;
        check_eq("bp_done_valid", 64'(OutValid), 64'd0);
        check_eq("bp_idle_rdy", 64'(InReady), 64'd1);
        ghost = 0;
        repeat (4) begin
            @(posedge Clock);
            #1;
            if (OutValid || !InReady) ghost++;
        end
        check_eq("bp_no_ghost", 64'(ghost), 64'd0);

        // Randomised operands and orders.
        for (int t = 0; t < 40; t++) begin
            if (t % 4 == 3) begin
                xr = $urandom;
            end else begin
                xr = BW'(int'($urandom_range(786432)) - 393216);
            end
            run_txn("rnd", xr, 4'($urandom_range(15)));
        end

        // Reset while in MUL_C abandons the computation.
        InValid = 1'b1;
        Datain  = 32'sh00010000;
        Order   = 4'd4;
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(OutValid), 64'd0);
        check_eq("mid_rst_data", 64'(DataOut), 64'd0);
        check_eq("mid_rst_ovf", 64'(Ovf), 64'd0);
        check_eq("mid_rst_oor", 64'(OutOfRange), 64'd0);
        check_eq("mid_rst_rdy", 64'(InReady), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        ghost = 0;
        repeat (12) begin
            @(posedge Clock);
            #1;
            if (OutValid) ghost++;
        end
        check_eq("mid_rst_noout", 64'(ghost), 64'd0);
        run_txn("post_rst", 32'sh00010000, 4'd4);
        check_eq("post_rst_data", 64'(DataOut), 64'h2B555);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exp_taylor_horner.md
EXP_TAYLOR_HORNER -- requirements
Module: exp_taylor_horner

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, signed fixed-point data width.
REQ-002 SHALL have parameter FRAC, default 16, fractional bits (Q(BITWIDTH-FRAC).FRAC).
REQ-003 SHALL have parameter MAX_ORDER, default 8, highest Taylor order supported, legal range 2..15.
REQ-004 SHALL have parameter INPUTMAX, default 5, integer magnitude bound for range flag.
REQ-005 SHALL have port Clock, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port Reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-007 SHALL have port InValid, input, 1, Datain/Order valid.
REQ-008 SHALL have port InReady, output, 1, block can accept.
REQ-009 SHALL have port Datain, input, BITWIDTH, signed operand x.
REQ-010 SHALL have port Order, input, 4, requested series order N.
REQ-011 SHALL have port OutValid, output, 1, DataOut valid.
REQ-012 SHALL have port OutReady, input, 1, consumer accepts.
REQ-013 SHALL have port DataOut, output, BITWIDTH, e^x approximation.
REQ-014 SHALL have port Ovf, output, 1, saturation occurred during this result.
REQ-015 SHALL have port OutOfRange, output, 1, |x| > INPUTMAX for this result.

Function
REQ-016 SHALL evaluate e^x by Horner: acc=1.0; for k=N..1: acc = 1.0 + ((acc*x)>>>FRAC)*C[k]>>>FRAC, C[k]=floor(2^FRAC/k).
REQ-017 SHALL use arithmetic right shift (truncate toward minus infinity) on each product, products held at 2*BITWIDTH.
REQ-018 SHALL saturate any product or sum exceeding BITWIDTH signed range to max/min value and set Ovf for that result.
REQ-019 SHALL clamp Order: 0 -> 1, >MAX_ORDER -> MAX_ORDER; clamped value latched at acceptance.
REQ-020 SHALL have FSM states IDLE, MUL_X, MUL_C, DONE.
REQ-021 SHALL, in IDLE, hold InReady=1; InValid&InReady at an edge latches x, N, acc=1.0, k=N, clears Ovf, computes OutOfRange, -> MUL_X.
REQ-022 SHALL, in MUL_X, form p=(acc*x)>>>FRAC; -> MUL_C.
REQ-023 SHALL, in MUL_C, set acc=1.0+(p*C[k])>>>FRAC; k=k-1; -> MUL_X if new k>0 else DONE.
REQ-024 SHALL assert OutValid in DONE exactly 2N edges after the accepting edge; DataOut, Ovf, OutOfRange stable while OutValid=1.
REQ-025 SHALL hold DONE while OutReady=0; OutValid&OutReady -> IDLE (no same-cycle new accept; InReady=0 outside IDLE).
REQ-026 SHALL ignore InValid, Datain and Order outside IDLE.
REQ-027 SHALL set OutOfRange when |x| > INPUTMAX*2^FRAC; x = min negative counts as out of range; computation proceeds unchanged.

Reset
REQ-028 SHALL, on Reset=0 asynchronously, force state IDLE, InReady=0 while asserted, OutValid=0, DataOut=0, Ovf=0, OutOfRange=0, acc/k/x=0.
REQ-029 SHALL abandon any in-flight computation on reset mid-operation; no OutValid follows for it.
REQ-030 SHALL assert InReady on the first edge after Reset deasserts.

Structure
REQ-031 SHALL take C[k] table (function of FRAC, k=1..15), ONE constant and state enum from shared package softmax_pkg.
REQ-032 SHALL instantiate one sub-module fxp_mul_sat (signed BITWIDTH x BITWIDTH, >>>FRAC, saturating, overflow flag), time-shared by MUL_X and MUL_C.

Verification (BITWIDTH=32, FRAC=16)
REQ-033 SHALL check x=0x00010000, Order=4 -> DataOut=0x0002B555, OutValid 8 edges after accept, Ovf=0.
REQ-034 SHALL check x=0xFFFF0000 (-1.0), Order=4 -> DataOut=0x00006000.
REQ-035 SHALL check x=0, Order=0 (clamped to 1) -> DataOut=0x00010000 after 2 edges; Order=15 with MAX_ORDER=8 -> latency 16.
REQ-036 SHALL check x=0x00060000 -> OutOfRange=1; x=0x7FFF0000, Order=8 -> Ovf=1, DataOut=0x7FFFFFFF.
REQ-037 SHALL check OutReady held 0 for 5 cycles -> DataOut stable, InReady=0, new InValid ignored; then one transfer and return to IDLE.
REQ-038 SHALL check Reset=0 asserted in MUL_C -> outputs zero immediately, next accepted x=1.0 yields 0x0002B555.
